uart_rx_port: RTL and testbench

Memory-mapped UART receiver peripheral for the single-cycle MIPS processor. It deserialises 8N1 frames from the board RX pin into a one-byte holding register, which the core reads over the peripheral data bus (addresses ≥ 0x40000000). It raises a level interrupt request that the processor ORs into its Interrupt term.

---
 rtl/uart_rx_port_if.sv | 15 +
 rtl/uart_rx_port.sv | 154 +++++++++++++++
 tb/tb_uart_rx_port.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_port_if.sv
// Peripheral data-bus bundle between the MIPS core and the UART receiver.
// The core drives strobes, address and write data; the peripheral returns read data and irq.
interface uart_rx_port_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output rd, output wr, output addr, output wdata,
                    input  rdata, input irq);
    modport slave  (input  rd, input  wr, input  addr, input  wdata,
                    output rdata, output irq);
endinterface

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling, one-byte holding register, level irq.
// state   | meaning
// S_IDLE  | line idle, waiting for a low sample on a tick
// S_START | start bit seen, confirm low at bit centre
// S_DATA  | shifting 8 data bits LSB first at bit centres
// S_STOP  | checking stop bit at its centre, then deliver or flag ferr
module uart_rx_port #(
    parameter int unsigned BAUD_DIV = 325,
    parameter logic [31:0] RXD_ADDR = 32'h4000_001C,
    parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    uart_rx_port_if.slave bus
);

    localparam int unsigned      DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_smp_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_ie;
    logic             r_ovr;
    logic             r_ferr;

    logic             w_tick;
    logic             w_smp_mid;
    logic             w_smp_end;
    logic             w_data_smp;
    logic             w_stop_smp;
    logic             w_deliver;
    logic             w_frame_err;
    logic             w_rxd_rd;
    logic             w_con_rd;
    logic             w_con_wr;
    logic [31:0]      w_rdata;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    assign w_smp_mid = (r_smp_cnt == 4'd7);
    assign w_smp_end = (r_smp_cnt == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick && !r_rx_s) w_state_nxt = S_START;
            S_START: if (w_tick && w_smp_mid) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && w_smp_end && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick && w_smp_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_data_smp = 1'b0;
        w_stop_smp = 1'b0;
        case (r_state)
            S_DATA:  w_data_smp = w_tick & w_smp_end;
            S_STOP:  w_stop_smp = w_tick & w_smp_end;
            default: ;
        endcase
    end

    assign w_deliver   = w_stop_smp &  r_rx_s;
    assign w_frame_err = w_stop_smp & ~r_rx_s;

    // smp_cnt restarts on every state change; in DATA it wraps 15->0 between bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (w_tick) begin
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_smp_cnt <= '0;
            else                                                 r_smp_cnt <= r_smp_cnt + 4'd1;
            if (r_state == S_START) r_bit_cnt <= '0;
            else if (w_data_smp)    r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_data_smp) r_shreg <= {r_rx_s, r_shreg[7:1]};
        end
    end

    assign w_rxd_rd = bus.rd && (bus.addr == RXD_ADDR);
    assign w_con_rd = bus.rd && (bus.addr == CON_ADDR);
    assign w_con_wr = bus.wr && (bus.addr == CON_ADDR);

    // A delivery landing on the RXD read edge refills the holder instead of overrunning.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ie       <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_con_wr) r_ie <= bus.wdata[0];

            if (w_deliver && (!r_rx_valid || w_rxd_rd)) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (w_rxd_rd) begin
                r_rx_valid <= 1'b0;
            end

            if (w_deliver && r_rx_valid && !w_rxd_rd) r_ovr <= 1'b1;
            else if (w_con_wr && bus.wdata[2])        r_ovr <= 1'b0;

            if (w_frame_err)                   r_ferr <= 1'b1;
            else if (w_con_wr && bus.wdata[3]) r_ferr <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rxd_rd)      w_rdata = {24'b0, r_rx_data};
        else if (w_con_rd) w_rdata = {28'b0, r_ferr, r_ovr, r_rx_valid, r_ie};
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_rx_valid & r_ie;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at BAUD_DIV=4 (64 clk per bit).
// Table-driven clean frames plus hand sequences for latency, overrun, glitch, framing and reset.
module tb_uart_rx_port;

    localparam int          BIT = 64;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rx    = 1'b1;
    int          checks   = 0;
    int          failures = 0;
    int unsigned tb_cyc;
    int          lat;
    logic [31:0] d;
    logic [31:0] d_sim;

    uart_rx_port_if bus();

    uart_rx_port #(.BAUD_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Tracks the DUT baud divider phase: both restart at reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic [31:0] exp_con;
        logic [31:0] exp_rxd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1 v = bus.rdata;
        @(negedge clk);
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = v;
        @(negedge clk);
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic align();
        @(negedge clk);
        while ((tb_cyc % 4) != 0) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_con(input string name, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(CON, v);
        check(name, v, exp);
    endtask

    task automatic check_rxd(input string name, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(RXD, v);
        check(name, v, exp);
    endtask

    initial begin
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        vecs[0] = '{8'h00, 32'h3, 32'h0000_0000};
        vecs[1] = '{8'hFF, 32'h3, 32'h0000_00FF};
        vecs[2] = '{8'h5A, 32'h3, 32'h0000_005A};
        vecs[3] = '{8'h01, 32'h3, 32'h0000_0001};
        vecs[4] = '{8'h80, 32'h3, 32'h0000_0080};
        vecs[5] = '{8'hC3, 32'h3, 32'h0000_00C3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        check("rst_rdata_idle", bus.rdata, 32'h0);
        reset = 1'b1;
        check_con("rst_con", 32'h0);
        check_rxd("rst_rxd", 32'h0);
        check_rxd("rst_rxd_valid_clear", 32'h0);
        bus_read(32'h4000_0024, d);
        check("unmapped_rd", d, 32'h0);
        bus_write(RXD, 32'hFF);
        check_rxd("rxd_write_ignored", 32'h0);

        // First frame: latency and irq handshake
        bus_write(CON, 32'h1);
        check_con("ie_set", 32'h1);
        @(negedge clk);
        bus.addr = CON;
        #1 check("rdata_no_rd", bus.rdata, 32'h0);
        bus.addr = '0;
        align();
        fork
            send_byte(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!bus.irq && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_irq", {31'b0, bus.irq}, 32'h1);
        check("a5_latency_window", {31'b0, (lat >= 600 && lat <= 624)}, 32'h1);
        check_con("a5_con", 32'h3);
        check_rxd("a5_rxd", 32'hA5);
        check("a5_irq_cleared", {31'b0, bus.irq}, 32'h0);

        // Clean frames from the table
        for (int i = 0; i < 6; i++) begin
            align();
            send_byte(vecs[i].data, 1'b1);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_irq", i), {31'b0, bus.irq}, 32'h1);
            check_con($sformatf("vec%0d_con", i), vecs[i].exp_con);
            check_rxd($sformatf("vec%0d_rxd", i), vecs[i].exp_rxd);
            check($sformatf("vec%0d_irq_low", i), {31'b0, bus.irq}, 32'h0);
            check_con($sformatf("vec%0d_con_after", i), 32'h1);
        end

        // Overrun: second byte dropped, ovr sticky until write-1-clear
        align();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check_con("ovr_con", 32'h7);
        bus_write(CON, 32'h5);
        check_con("ovr_cleared_con", 32'h3);
        check_rxd("ovr_rxd_first_kept", 32'h3C);
        check_con("ovr_con_after_read", 32'h1);

        // Start-bit glitch rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check_con("glitch_con", 32'h1);
        check("glitch_irq", {31'b0, bus.irq}, 32'h0);

        // Framing error
        align();
        send_byte(8'h55, 1'b0);
        repeat (150) @(negedge clk);
        check_con("ferr_con", 32'h9);
        check("ferr_irq", {31'b0, bus.irq}, 32'h0);
        bus_write(CON, 32'h9);
        check_con("ferr_cleared_con", 32'h1);

        // RXD read on the exact delivery edge of a second byte
        align();
        send_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk);
        check_con("sim_pre_con", 32'h3);
        align();
        fork
            send_byte(8'h81, 1'b1);
            begin
                repeat (lat - 1) @(negedge clk);
                bus.rd   = 1'b1;
                bus.addr = RXD;
                #1 d_sim = bus.rdata;
                @(negedge clk);
                bus.rd   = 1'b0;
                bus.addr = '0;
            end
        join
        check("sim_old_byte", d_sim, 32'h44);
        check_con("sim_con", 32'h3);
        check_rxd("sim_rxd_new", 32'h81);

        // Reset mid-DATA of 0xFF, then a clean 0x12
        bus_write(CON, 32'h1);
        align();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (200) @(negedge clk);
                reset = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check_con("midrst_con", 32'h0);
        check("midrst_irq", {31'b0, bus.irq}, 32'h0);
        check_rxd("midrst_rxd", 32'h0);
        bus_write(CON, 32'h1);
        align();
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        check_con("post_rst_con", 32'h3);
        check_rxd("post_rst_rxd", 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
